// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with valid/ready output and optional round-robin arbitration.
// Result is held in a one-entry output register until the consumer accepts it.
module prio_encoder_rr #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] y
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   y_reg, y_next;
    logic [W-1:0]   ptr_reg, ptr_next;
    logic [W-1:0]   eff_ptr;
    logic [W-1:0]   win_any, win_low, winner;
    logic [N-1:0]   below_mask, req_low;
    logic           handshake, load, any_low;

    assign handshake = (state_reg == FULL) && out_ready;
    assign load      = en && (|req) && ((state_reg == EMPTY) || out_ready);

    // Pointer bypass: a grant accepted this cycle already lowers its own priority for the new search.
    assign eff_ptr = ((MODE == 1) && handshake) ? y_reg : ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign below_mask[gi] = (32'(gi) < 32'(eff_ptr));
        end
    endgenerate

    assign req_low = req & below_mask;
    assign any_low = |req_low;

    // Rotating search = highest request below ptr, else highest request overall.
    always_comb begin
        win_any = '0;
        win_low = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i])
                win_any = W'(i);
            if (req_low[i])
                win_low = W'(i);
        end
    end

    assign winner = any_low ? win_low : win_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            y_reg     <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        ptr_next   = ptr_reg;
        if (load) begin
            state_next = FULL;
            y_next     = winner;
        end else if (handshake) begin
            state_next = EMPTY;
        end
        if ((MODE == 1) && handshake)
            ptr_next = y_reg;
    end

    always_comb begin
        out_valid = (state_reg == FULL);
        y         = y_reg;
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: four instances (N=8/5, fixed/round-robin) against a search-order model.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       out_ready;
    logic [7:0] req8;
    logic [4:0] req5;

    logic       dv[4];
    logic [2:0] dy[4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .MODE(0)) u_f8 (.clk(clk), .rst(rst), .en(en), .req(req8),
        .out_ready(out_ready), .out_valid(dv[0]), .y(dy[0]));
    prio_encoder_rr #(.N(8), .MODE(1)) u_r8 (.clk(clk), .rst(rst), .en(en), .req(req8),
        .out_ready(out_ready), .out_valid(dv[1]), .y(dy[1]));
    prio_encoder_rr #(.N(5), .MODE(0)) u_f5 (.clk(clk), .rst(rst), .en(en), .req(req5),
        .out_ready(out_ready), .out_valid(dv[2]), .y(dy[2]));
    prio_encoder_rr #(.N(5), .MODE(1)) u_r5 (.clk(clk), .rst(rst), .en(en), .req(req5),
        .out_ready(out_ready), .out_valid(dv[3]), .y(dy[3]));

    function automatic int n_of(int i);
        return (i < 2) ? 8 : 5;
    endfunction

    function automatic int mode_of(int i);
        return i % 2;
    endfunction

    // Walk ptr-1, ptr-2, ... modulo n; first active requester wins.
    function automatic int search_win(int n, int ptr, logic [7:0] r);
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (ptr - k + 2 * n) % n;
            if (r[idx])
                return idx;
        end
        return -1;
    endfunction

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Model state per instance.
    logic       mv[4];
    int         my[4];
    int         mp[4];
    logic       nv[4];
    int         ny[4];
    int         np[4];
    logic       hs_t[4];
    int         ep_t[4];
    logic [7:0] r_t[4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nv[i]   = mv[i];
            ny[i]   = my[i];
            np[i]   = mp[i];
            r_t[i]  = (i < 2) ? req8 : {3'b000, req5};
            hs_t[i] = mv[i] && out_ready;
            ep_t[i] = (mode_of(i) == 1 && hs_t[i]) ? my[i] : mp[i];
            if (en && (r_t[i] != 8'd0) && (!mv[i] || out_ready)) begin
                nv[i] = 1'b1;
                ny[i] = search_win(n_of(i), ep_t[i], r_t[i]);
            end else if (hs_t[i]) begin
                nv[i] = 1'b0;
            end
            if (mode_of(i) == 1 && hs_t[i])
                np[i] = my[i];
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mv[i] <= 1'b0;
                my[i] <= 0;
                mp[i] <= 0;
            end else begin
                mv[i] <= nv[i];
                my[i] <= ny[i];
                mp[i] <= np[i];
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_valid[%0d]", i), int'(dv[i]), int'(mv[i]));
                chk($sformatf("model_y[%0d]", i), int'(dy[i]), my[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int e_r8[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int e_r5[9] = '{4, 3, 2, 1, 0, 4, 3, 2, 1};
    int e_sp[4] = '{7, 0, 7, 0};

    initial begin
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; req8 = '0; req5 = '0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_valid[%0d]", i), int'(dv[i]), 0);
            chk($sformatf("reset_y[%0d]", i), int'(dy[i]), 0);
        end
        rst = 1'b0;

        // Fixed priority with backpressure.
        en = 1'b1; req8 = 8'b0010_1100; req5 = 5'b10010; out_ready = 1'b0;
        tick();
        chk("fixed_first_valid", int'(dv[0]), 1);
        chk("fixed_first_y", int'(dy[0]), 5);
        chk("fixed5_y", int'(dy[2]), 4);
        req8 = 8'h80;
        tick();
        tick();
        chk("fixed_hold_y", int'(dy[0]), 5);
        chk("fixed_hold_valid", int'(dv[0]), 1);
        out_ready = 1'b1;
        tick();
        chk("fixed_after_hs_y", int'(dy[0]), 7);
        chk("fixed_after_hs_valid", int'(dv[0]), 1);
        en = 1'b0;
        tick();
        chk("drain_valid", int'(dv[0]), 0);
        chk("drain_keeps_y", int'(dy[0]), 7);

        // Disabled, then zero request.
        req8 = 8'hFF; req5 = 5'h1F;
        for (int k = 0; k < 3; k++) begin
            out_ready = k[0];
            tick();
            chk("disabled_valid", int'(dv[1]), 0);
        end
        en = 1'b1; req8 = '0; req5 = '0;
        for (int k = 0; k < 3; k++) begin
            out_ready = ~k[0];
            tick();
            chk("zero_req_valid", int'(dv[0]), 0);
        end

        // Reset while holding a result.
        req8 = 8'b0010_1100; out_ready = 1'b0;
        tick();
        chk("pre_reset_y", int'(dy[0]), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", int'(dv[0]), 0);
        chk("async_reset_y", int'(dy[0]), 0);
        chk("async_reset_rr_valid", int'(dv[1]), 0);
        tick();
        rst = 1'b0;

        // Round-robin with every requester active.
        req8 = 8'hFF; req5 = 5'h1F; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr8_full_y[%0d]", k), int'(dy[1]), e_r8[k]);
            chk($sformatf("rr8_full_valid[%0d]", k), int'(dv[1]), 1);
            chk($sformatf("rr5_full_y[%0d]", k), int'(dy[3]), e_r5[k]);
            chk($sformatf("fixed5_full_y[%0d]", k), int'(dy[2]), 4);
        end

        // Sparse round-robin, then backpressure.
        out_ready = 1'b0;
        pulse_reset();
        req8 = 8'b1000_0001; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_sparse_y[%0d]", k), int'(dy[1]), e_sp[k]);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_sparse_hold_y", int'(dy[1]), 0);
            chk("rr_sparse_hold_valid", int'(dv[1]), 1);
        end
        out_ready = 1'b1;
        tick();
        chk("rr_sparse_resume_y", int'(dy[1]), 7);

        en = 1'b0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered priority encoder with a valid/ready output and a selectable round-robin mode. It takes an N-bit request vector, qualified by an enable, and produces the index of the winning request. The result sits in an output register and is held until the consumer accepts it. It sits between raw request sources (switches, scancode-decoder strobes, IRQ lines) and a downstream consumer that may stall.

## Interface
- `N`, default 8: request width; legal range 2..256.
- `MODE`, default 0: arbitration mode.
  - 0 = fixed priority, highest index wins.
  - 1 = round-robin, rotating from the last accepted index.
- `W`, localparam `$clog2(N)`: index width; not overridable.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  sample enable; requests are ignored while low.
- `req`  in  N  request vector; bit i set means requester i is active.
- `out_ready`  in  1  consumer accepts `y` this cycle.
- `out_valid`  out  1  `y` holds a valid, unconsumed result.
- `y`  out  W  encoded winning index, 0..N-1.

## Operation
- **Output register.** The output is a one-entry register with two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- **Load condition.** `load = en && (req != 0) && (!out_valid || out_ready)`.
  - On `load`: `y` <= winning index and `out_valid` <= 1.
  - FULL with `out_ready`=1 and no `load` → EMPTY; `y` keeps its last value.
  - FULL with `out_ready`=0 → `y` and `out_valid` stay frozen, regardless of changes on `req` or `en`.
- **Zero or disabled input.** `req`=0 or `en`=0 never produces a result; there is no "index 0 by default" output.
- **Fixed mode (MODE=0).** Winner is the highest set bit of `req`. Example: `req`=8'b0010_1100 gives 5.
- **Round-robin mode (MODE=1).** Internal pointer `ptr` (W bits) holds the last accepted index.
  - Search order is ptr-1, ptr-2, …, 0, N-1, …, ptr, with modulo-N wrap. The last winner therefore has the lowest priority.
  - `ptr` updates to `y` only on a handshake (`out_valid && out_ready`), never on load alone.
  - With reset `ptr`=0, the first search order is N-1 down to 0, which matches fixed mode.
  - In MODE=0, `ptr` is unused and constant 0.
- **Non-power-of-two N.** `y` never exceeds N-1. Wrap goes from 0 to N-1, not to 2^W-1.
- **Simultaneous events.** A handshake and a load in the same cycle are allowed. `ptr` takes the old `y`, and the new search in that same cycle already uses the updated pointer value (bypass), so back-to-back round-robin grants never repeat an index.
- **Combinational path.** The winner search is purely combinational from `req`, `en` and `ptr` to the register D input. There is no combinational path from `req` to `y`.

## Timing
- Reset values (asynchronous, take effect immediately on `rst`=1): `out_valid`=0, `y`=0, `ptr`=0.
- Reset mid-operation discards any held result; no handshake is reported.
- Latency: `req` sampled at edge k appears on `y` with `out_valid` after edge k, i.e. one cycle.
- Throughput: one result per cycle while `out_ready`=1 and requests are present.
- Handshake rules:
  - `out_valid`, once high, stays high and `y` stays stable until `out_ready` is sampled high.
  - `out_ready` may toggle freely while `out_valid`=0, with no effect.
- Deassert of `rst` is assumed to be synchronised to `clk` outside this block.

## Test plan
- **Reset mid-hold:** N=8, FULL with `y`=5, `out_ready`=0; assert `rst` between edges → `out_valid`=0 and `y`=0 before the next edge; after release, `ptr` restarts at 0.
- **Fixed priority with backpressure:** MODE=0, `en`=1, `req`=8'b0010_1100, `out_ready`=0 → `y`=5, valid after 1 cycle. Then switch `req`=8'h80 → `y` stays 5 until `out_ready`=1. The edge after the handshake gives `y`=7.
- **Round-robin, full request:** MODE=1, `req`=8'hFF constant, `out_ready`=1 → `y` sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, `out_valid` continuously 1.
- **Round-robin, sparse request:** MODE=1, `req`=8'b1000_0001, `out_ready`=1 → `y` alternates 7,0,7,0. With `out_ready`=0 for 3 cycles, `y` holds and `ptr` is unchanged.
- **Disabled or zero input:** `en`=0 with `req`=8'hFF, or `en`=1 with `req`=0 → `out_valid` never rises. A FULL result is drained by one `out_ready` pulse, then EMPTY.
- **Non-power-of-two:** N=5 (W=3):
  - MODE=0, `req`=5'b10010 → `y`=4.
  - MODE=1, `req`=5'b11111 → `y` sequence 4,3,2,1,0,4; `y` never reaches 5..7.
